onehot_key_capture: RTL and testbench
=====================================

Name: onehot_key_capture

Overview:
Upstream front-end for the one-hot-to-binary converter on the dedicated inputs. It synchronises raw push-button/switch lines, debounces them, and accepts only clean single-key presses. Each accepted press is presented as a registered, sticky one-hot vector with a one-cycle strobe. Multi-key presses are rejected and flagged, so the downstream converter only ever sees a legal one-hot code or all-zero.

Parameters:
INPUTS, 8, number of key lines; also the width of the one-hot output.
DEBOUNCE, 16, consecutive stable cycles required to accept a press or a release; legal range is at least 1.
CNT_W, $clog2(DEBOUNCE+1), width of the debounce counter; derived, never overridden.

Ports:
clk  input  1  single clock.
rst  input  1  reset, asynchronous and active-high.
keys_in  input  INPUTS  raw, asynchronous, bouncing key lines; active-high.
onehot_out  output  INPUTS  last accepted key, one-hot; all-zero until the first valid press.
press_pulse  output  1  high for exactly one cycle when onehot_out is updated.
multi_err  output  1  high for exactly one cycle when a stable multi-key press is rejected.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous, active-high. While rst is high, all flops clear: both sync stages, candidate, counter, state=IDLE, onehot_out=0, press_pulse=0, multi_err=0, busy=0. A reset mid-debounce discards the candidate with no pulse.
- Synchroniser: 2-flop per bit. s2 is the synced vector; the FSM reads only s2.
- State IDLE:
  - s2==0: stay.
  - s2!=0: candidate<=s2, cnt<=0, go DEBOUNCE.
- State DEBOUNCE:
  - s2==0: go IDLE (bounce rejected).
  - s2!=0 and s2!=candidate: candidate<=s2, cnt<=0.
  - s2==candidate and cnt<DEBOUNCE-1: cnt<=cnt+1.
  - s2==candidate and cnt==DEBOUNCE-1: commit.
    - popcount(candidate)==1: onehot_out<=candidate, press_pulse<=1.
    - Otherwise: multi_err<=1 and onehot_out unchanged.
    - Either way: cnt<=0, go HELD.
- State HELD (waiting for release):
  - s2!=0: cnt<=0.
  - s2==0 and cnt<DEBOUNCE-1: cnt<=cnt+1.
  - s2==0 and cnt==DEBOUNCE-1: go IDLE, no pulse.
  - A new key pressed while holding is ignored until a full release is seen.
- Latency: number clock edges from 1, where edge 1 is the first edge that samples a new stable keys_in. press_pulse or multi_err is high in the cycle after edge DEBOUNCE+3, i.e. edge 7 for DEBOUNCE=4.
- Pulses: press_pulse and multi_err are registered, never high together, and high for one cycle only.
- onehot_out: sticky through release and through rejected presses. It changes only on an accepted press, or on reset.
- busy: registered as (next_state != IDLE), so it is aligned with the state register.
- Counter: saturation cannot occur, because cnt never exceeds DEBOUNCE-1. With DEBOUNCE=1, a commit happens on the first edge in DEBOUNCE where s2==candidate.

Decomposition:
- Package onehot_key_pkg holds:
  - the state enum {IDLE, DEBOUNCE, HELD}, 2 bits;
  - a popcount_is_one function, parameterised by width via a loop.
- Sub-module sync_2ff (width parameter, async active-high reset): a reusable synchroniser, instantiated once with width INPUTS.
- FSM, counter and output registers live in onehot_key_capture itself.

Test Plan:
- Clean press (DEBOUNCE=4): keys_in=0x08 held from edge 1.
  - press_pulse is high after edge 7 for 1 cycle and onehot_out=0x08.
  - After release for 4+ cycles, onehot_out stays 0x08 and busy returns to 0.
- Bounce: keys_in toggles 0x08/0x00 every 2 cycles for 20 cycles, then holds 0x08. No pulse occurs during bouncing, and press_pulse fires exactly DEBOUNCE+3 edges after the final stable 0x08.
- Multi-key: keys_in=0x0C stable. multi_err is high for 1 cycle at edge 7, press_pulse stays 0, and onehot_out keeps its previous value (0x08).
- Roll-over: hold 0x08, then change to 0x09 before release.
  - No new event occurs.
  - After a full release and then 0x01 stable, onehot_out=0x01 with one press_pulse.
- Async reset mid-debounce: assert rst at edge 5 of a 0x20 press (between clock edges).
  - All outputs clear immediately, before the next edge.
  - Deassert rst with the key still held: a press_pulse follows DEBOUNCE+3 edges later with onehot_out=0x20.
- DEBOUNCE=1 corner: keys_in=0x80 held. press_pulse appears after edge 4, onehot_out=0x80.

Source files
------------

// File: rtl/onehot_key_pkg.sv
// Shared types and helpers for the key-capture front-end.
// Holds the FSM state encoding and a width-aware single-bit-set test.
package onehot_key_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  // Widest key vector popcount_is_one can inspect; callers zero-extend.
  localparam int MAX_KEYS = 64;

  function automatic logic popcount_is_one(input logic [MAX_KEYS-1:0] vec,
                                           input int                  width);
    int ones;
    ones = 0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if ((i < width) && vec[i]) ones++;
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a vector of asynchronous inputs.
// Each bit is synchronised independently; q is two clocks behind d.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/onehot_key_capture.sv
// Synchronises, debounces and qualifies raw key lines into a sticky one-hot
// code; multi-key presses are rejected with a single-cycle error strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no key seen; waiting for any non-zero synced vector
// DEBOUNCE | candidate captured; counting consecutive identical samples
// HELD     | press committed or rejected; waiting for a stable release
module onehot_key_capture
  import onehot_key_pkg::*;
#(
  parameter int INPUTS   = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INPUTS-1:0] keys_in,
  output logic [INPUTS-1:0] onehot_out,
  output logic              press_pulse,
  output logic              multi_err,
  output logic              busy
);

  localparam int             CNT_W    = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [INPUTS-1:0] s2;

  sync_2ff #(
    .WIDTH(INPUTS)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (keys_in),
    .q  (s2)
  );

  state_t            state, state_nxt;
  logic [INPUTS-1:0] cand, cand_nxt;
  logic [INPUTS-1:0] onehot_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              press_nxt;
  logic              err_nxt;
  logic              key_down;
  logic              cand_match;
  logic              cnt_done;
  logic              cand_single;

  assign key_down    = |s2;
  assign cand_match  = (s2 == cand);
  assign cnt_done    = (cnt == CNT_LAST);
  assign cand_single = popcount_is_one(MAX_KEYS'(cand), INPUTS);

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    onehot_nxt = onehot_out;
    press_nxt  = 1'b0;
    err_nxt    = 1'b0;

    case (state)
      onehot_key_pkg::IDLE: begin
        if (key_down) begin
          cand_nxt  = s2;
          cnt_nxt   = '0;
          state_nxt = onehot_key_pkg::DEBOUNCE;
        end
      end

      onehot_key_pkg::DEBOUNCE: begin
        if (!key_down) begin
          state_nxt = onehot_key_pkg::IDLE;
        end else if (!cand_match) begin
          cand_nxt = s2;
          cnt_nxt  = '0;
        end else if (!cnt_done) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          // Stable long enough: accept a lone key, reject chords.
          if (cand_single) begin
            onehot_nxt = cand;
            press_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
          cnt_nxt   = '0;
          state_nxt = onehot_key_pkg::HELD;
        end
      end

      onehot_key_pkg::HELD: begin
        if (key_down) begin
          cnt_nxt = '0;
        end else if (!cnt_done) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          state_nxt = onehot_key_pkg::IDLE;
        end
      end

      default: begin
        state_nxt = onehot_key_pkg::IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= onehot_key_pkg::IDLE;
      cand        <= '0;
      cnt         <= '0;
      onehot_out  <= '0;
      press_pulse <= 1'b0;
      multi_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      cnt         <= cnt_nxt;
      onehot_out  <= onehot_nxt;
      press_pulse <= press_nxt;
      multi_err   <= err_nxt;
      busy        <= (state_nxt != onehot_key_pkg::IDLE);
    end
  end

endmodule

// File: tb/tb_onehot_key_capture.sv
// Bench for onehot_key_capture: run-length reference model plus directed
// vectors, on one instance with DEBOUNCE=4 and one with DEBOUNCE=1.
module tb_onehot_key_capture;

  logic       clk;
  logic       rst;
  logic [7:0] keys_a, keys_b;
  logic [7:0] onehot_a, onehot_b;
  logic       press_a, press_b;
  logic       err_a, err_b;
  logic       busy_a, busy_b;

  int checks   = 0;
  int failures = 0;
  int n_events_a = 0;

  onehot_key_capture #(.INPUTS(8), .DEBOUNCE(4)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .keys_in    (keys_a),
    .onehot_out (onehot_a),
    .press_pulse(press_a),
    .multi_err  (err_a),
    .busy       (busy_a)
  );

  onehot_key_capture #(.INPUTS(8), .DEBOUNCE(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .keys_in    (keys_b),
    .onehot_out (onehot_b),
    .press_pulse(press_b),
    .multi_err  (err_b),
    .busy       (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an event fires when the synced value has been the same non-zero
  // code for d+1 samples while armed; re-arm after d consecutive zero samples.
  typedef struct {
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] last;
    int         run;
    bit         armed;
    logic [7:0] onehot;
    bit         press;
    bit         err;
    bit         busy;
  } model_t;

  model_t m_a, m_b;

  function automatic model_t model_reset();
    model_t m;
    m.s1 = '0; m.s2 = '0; m.last = '0; m.run = 0; m.armed = 1'b1;
    m.onehot = '0; m.press = 1'b0; m.err = 1'b0; m.busy = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, logic [7:0] keys, int d);
    logic [7:0] sample;
    sample = m.s2;
    m.s2   = m.s1;
    m.s1   = keys;
    if (sample == m.last) begin
      if (m.run < 100000) m.run++;
    end else begin
      m.run = 1;
    end
    m.last  = sample;
    m.press = 1'b0;
    m.err   = 1'b0;
    if (m.armed) begin
      if (sample != 0 && m.run == d + 1) begin
        m.armed = 1'b0;
        if ($countones(sample) == 1) begin
          m.onehot = sample;
          m.press  = 1'b1;
        end else begin
          m.err = 1'b1;
        end
      end
    end else if (sample == 0 && m.run == d) begin
      m.armed = 1'b1;
    end
    m.busy = !m.armed || (sample != 0);
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= model_reset();
      m_b <= model_reset();
    end else begin
      m_a <= model_step(m_a, keys_a, 4);
      m_b <= model_step(m_b, keys_b, 1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("a_onehot", 32'(onehot_a), 32'(m_a.onehot));
      check("a_press",  32'(press_a),  32'(m_a.press));
      check("a_err",    32'(err_a),    32'(m_a.err));
      check("a_busy",   32'(busy_a),   32'(m_a.busy));
      check("b_onehot", 32'(onehot_b), 32'(m_b.onehot));
      check("b_press",  32'(press_b),  32'(m_b.press));
      check("b_err",    32'(err_b),    32'(m_b.err));
      check("b_busy",   32'(busy_b),   32'(m_b.busy));
      if (press_a || err_a) n_events_a++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int ev_snap;

  initial begin
    rst    = 1'b1;
    keys_a = '0;
    keys_b = '0;
    tick(2);
    check("rst_onehot_a", 32'(onehot_a), 32'h0);
    check("rst_press_a",  32'(press_a),  32'h0);
    check("rst_err_a",    32'(err_a),    32'h0);
    check("rst_busy_a",   32'(busy_a),   32'h0);
    check("rst_onehot_b", 32'(onehot_b), 32'h0);
    rst = 1'b0;
    tick(3);

    // Clean press of 0x08
    keys_a = 8'h08;
    tick(6);
    check("clean_no_early_pulse", 32'(press_a), 32'h0);
    tick(1);
    check("clean_pulse_edge7", 32'(press_a), 32'h1);
    check("clean_onehot", 32'(onehot_a), 32'h08);
    check("model_pin_press", 32'(m_a.press), 32'h1);
    tick(1);
    check("clean_pulse_one_cycle", 32'(press_a), 32'h0);
    tick(3);
    keys_a = 8'h00;
    tick(10);
    check("release_sticky", 32'(onehot_a), 32'h08);
    check("release_busy", 32'(busy_a), 32'h0);
    check("model_pin_busy", 32'(m_a.busy), 32'h0);

    // Bounce then settle
    ev_snap = n_events_a;
    for (int i = 0; i < 5; i++) begin
      keys_a = 8'h08; tick(2);
      keys_a = 8'h00; tick(2);
    end
    check("bounce_no_event", 32'(n_events_a), 32'(ev_snap));
    keys_a = 8'h08;
    tick(6);
    check("bounce_no_early_pulse", 32'(press_a), 32'h0);
    tick(1);
    check("bounce_pulse_edge7", 32'(press_a), 32'h1);
    keys_a = 8'h00;
    tick(10);

    // Multi-key rejected
    keys_a = 8'h0C;
    tick(7);
    check("multi_err_edge7", 32'(err_a), 32'h1);
    check("multi_no_press", 32'(press_a), 32'h0);
    check("multi_onehot_kept", 32'(onehot_a), 32'h08);
    check("model_pin_err", 32'(m_a.err), 32'h1);
    tick(1);
    check("multi_err_one_cycle", 32'(err_a), 32'h0);
    keys_a = 8'h00;
    tick(10);

    // Roll-over while held
    keys_a = 8'h08;
    tick(10);
    ev_snap = n_events_a;
    keys_a = 8'h09;
    tick(12);
    check("rollover_no_event", 32'(n_events_a), 32'(ev_snap));
    check("rollover_busy_held", 32'(busy_a), 32'h1);
    keys_a = 8'h00;
    tick(10);
    keys_a = 8'h01;
    tick(7);
    check("rollover_new_press", 32'(press_a), 32'h1);
    check("rollover_onehot", 32'(onehot_a), 32'h01);
    keys_a = 8'h00;
    tick(10);

    // Asynchronous reset mid-debounce
    keys_a = 8'h20;
    tick(5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_onehot", 32'(onehot_a), 32'h0);
    check("async_rst_press",  32'(press_a),  32'h0);
    check("async_rst_busy",   32'(busy_a),   32'h0);
    check("async_rst_err",    32'(err_a),    32'h0);
    tick(1);
    rst = 1'b0;
    tick(6);
    check("post_rst_no_early", 32'(press_a), 32'h0);
    tick(1);
    check("post_rst_pulse", 32'(press_a), 32'h1);
    check("post_rst_onehot", 32'(onehot_a), 32'h20);
    keys_a = 8'h00;
    tick(10);

    // DEBOUNCE=1 corner
    keys_b = 8'h80;
    tick(3);
    check("d1_no_early", 32'(press_b), 32'h0);
    tick(1);
    check("d1_pulse_edge4", 32'(press_b), 32'h1);
    check("d1_onehot", 32'(onehot_b), 32'h80);
    tick(1);
    check("d1_pulse_one_cycle", 32'(press_b), 32'h0);
    keys_b = 8'h00;
    tick(5);
    keys_b = 8'h81;
    tick(4);
    check("d1_multi_err", 32'(err_b), 32'h1);
    check("d1_multi_onehot_kept", 32'(onehot_b), 32'h80);
    keys_b = 8'h00;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
